// File: rtl/pwm_duty_monitor.sv
// Per-channel PWM duty-cycle monitor: counts synchronised high cycles over a
// fixed window and hands each window's result to a consumer via valid/ready.
module pwm_duty_monitor #(
  parameter int unsigned CHANNELS      = 3,
  parameter int unsigned PERIOD_CYCLES = 256,
  parameter int unsigned SYNC_STAGES   = 2,
  localparam int unsigned CNT_W        = $clog2(PERIOD_CYCLES + 1)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      enable,
  input  logic [CHANNELS-1:0]       pwm_in,
  output logic [CHANNELS*CNT_W-1:0] duty_out,
  output logic [CHANNELS-1:0]       active_out,
  output logic                      duty_valid,
  input  logic                      duty_ready,
  output logic                      overrun,
  input  logic                      clr_overrun
);

  localparam int unsigned WCNT_W = $clog2(PERIOD_CYCLES);
  localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(PERIOD_CYCLES - 1);

  logic [CHANNELS-1:0] sync_q [SYNC_STAGES];
  logic [CHANNELS-1:0] s;
  logic [CHANNELS-1:0] s_prev;

  logic [WCNT_W-1:0]   wcnt;
  logic [CNT_W-1:0]    hcnt    [CHANNELS];
  logic [CNT_W-1:0]    fin_cnt [CHANNELS];
  logic [CHANNELS-1:0] act;
  logic [CHANNELS-1:0] fin_act;

  logic win_end;
  logic load;
  logic lost;

  assign s = sync_q[SYNC_STAGES-1];

  // Input synchroniser plus previous-sample register for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < SYNC_STAGES; k++) begin
        sync_q[k] <= '0;
      end
      s_prev <= '0;
    end else begin
      sync_q[0] <= pwm_in;
      for (int unsigned k = 1; k < SYNC_STAGES; k++) begin
        sync_q[k] <= sync_q[k-1];
      end
      s_prev <= s;
    end
  end

  // Running totals including this cycle's sample; these are the window result at window end.
  always_comb begin
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      fin_cnt[i] = hcnt[i] + CNT_W'(s[i]);
    end
    fin_act = act | (s ^ s_prev);
  end

  assign win_end = enable && (wcnt == WCNT_LAST);
  assign load    = win_end && (!duty_valid || duty_ready);
  assign lost    = win_end && duty_valid && !duty_ready;

  // Window accumulation; disabling aborts the partial window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wcnt <= '0;
      act  <= '0;
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        hcnt[i] <= '0;
      end
    end else if (!enable || win_end) begin
      wcnt <= '0;
      act  <= '0;
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        hcnt[i] <= '0;
      end
    end else begin
      wcnt <= wcnt + WCNT_W'(1);
      act  <= fin_act;
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        hcnt[i] <= fin_cnt[i];
      end
    end
  end

  // Result holding register with valid/ready handshake; an unaccepted result blocks newer ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      duty_out   <= '0;
      active_out <= '0;
      duty_valid <= 1'b0;
    end else if (load) begin
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        duty_out[i*CNT_W +: CNT_W] <= fin_cnt[i];
      end
      active_out <= fin_act;
      duty_valid <= 1'b1;
    end else if (duty_valid && duty_ready) begin
      duty_valid <= 1'b0;
    end
  end

  // Sticky lost-window flag; a new loss outranks a clear in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun <= 1'b0;
    end else if (lost) begin
      overrun <= 1'b1;
    end else if (clr_overrun) begin
      overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pwm_duty_monitor.sv
// Bench for pwm_duty_monitor: directed scenarios with known counts, then a
// randomized run compared against a window-level reference model.
module tb_pwm_duty_monitor;

  localparam int C  = 3;
  localparam int P  = 16;
  localparam int SS = 2;
  localparam int CW = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b0;
  logic [C-1:0]  pwm_in = '0;
  logic [C*CW-1:0] duty_out;
  logic [C-1:0]  active_out;
  logic          duty_valid;
  logic          duty_ready = 1'b1;
  logic          overrun;
  logic          clr_overrun = 1'b0;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pwm_duty_monitor #(
    .CHANNELS(C), .PERIOD_CYCLES(P), .SYNC_STAGES(SS)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .pwm_in(pwm_in),
    .duty_out(duty_out), .active_out(active_out), .duty_valid(duty_valid),
    .duty_ready(duty_ready), .overrun(overrun), .clr_overrun(clr_overrun)
  );

  // Reference model: synchroniser is a pure SS-cycle delay line; each window is
  // the list of samples seen while enabled, summed and scanned for changes at its end.
  logic [C-1:0]    pipe [$];
  logic [C-1:0]    ws [$];
  logic [C-1:0]    s_cur, last_s, win_prev;
  logic [C*CW-1:0] m_duty, w_cnt;
  logic [C-1:0]    m_act, w_act;
  logic            m_valid, m_ovr, wend, lost, pb, tr;
  int              sum;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe.delete();
      for (int k = 0; k < SS; k++) pipe.push_back('0);
      ws.delete();
      last_s = '0; win_prev = '0;
      m_duty = '0; m_act = '0; m_valid = 1'b0; m_ovr = 1'b0;
    end else begin
      s_cur = pipe.pop_front();
      pipe.push_back(pwm_in);
      wend = 1'b0;
      lost = 1'b0;
      if (!enable) begin
        ws.delete();
      end else begin
        if (ws.size() == 0) win_prev = last_s;
        ws.push_back(s_cur);
        if (ws.size() == P) begin
          wend = 1'b1;
          for (int i = 0; i < C; i++) begin
            sum = 0;
            tr = 1'b0;
            for (int k = 0; k < P; k++) begin
              sum += int'(ws[k][i]);
              pb = (k == 0) ? win_prev[i] : ws[k-1][i];
              if (ws[k][i] != pb) tr = 1'b1;
            end
            w_cnt[i*CW +: CW] = CW'(sum);
            w_act[i] = tr;
          end
          if (!m_valid || duty_ready) begin
            m_duty = w_cnt; m_act = w_act; m_valid = 1'b1;
          end else begin
            lost = 1'b1;
          end
          ws.delete();
        end
      end
      if (!wend && m_valid && duty_ready) m_valid = 1'b0;
      if (lost) m_ovr = 1'b1;
      else if (clr_overrun) m_ovr = 1'b0;
      last_s = s_cur;
    end
  end

  function automatic int ch(input logic [C*CW-1:0] d, input int i);
    return int'(d[i*CW +: CW]);
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; enable = 1'b0; duty_ready = 1'b1; clr_overrun = 1'b0; pwm_in = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_vec++; if (duty_out !== '0) begin n_err++; $display("FAIL reset_duty: got %h want 0", duty_out); end
    n_vec++; if (active_out !== '0) begin n_err++; $display("FAIL reset_active: got %b want 0", active_out); end
    n_vec++; if (duty_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", duty_valid); end
    n_vec++; if (overrun !== 1'b0) begin n_err++; $display("FAIL reset_overrun: got %b want 0", overrun); end
  endtask

  task automatic test_constant();
    logic exp_v;
    do_reset();
    pwm_in = 3'b001; enable = 1'b1; duty_ready = 1'b1;
    for (int t = 1; t <= 48; t++) begin
      tick();
      exp_v = ((t % 16) == 0);
      n_vec++; if (duty_valid !== exp_v) begin n_err++; $display("FAIL const_valid t=%0d: got %b want %b", t, duty_valid, exp_v); end
      if (t == 16) begin
        n_vec++; if (ch(duty_out, 0) != 14) begin n_err++; $display("FAIL const_first_ch0: got %0d want 14", ch(duty_out, 0)); end
        n_vec++; if (active_out !== 3'b001) begin n_err++; $display("FAIL const_first_active: got %b want 001", active_out); end
      end else if (exp_v) begin
        n_vec++; if (duty_out !== {5'd0, 5'd0, 5'd16}) begin n_err++; $display("FAIL const_duty t=%0d: got %h want 010", t, duty_out); end
        n_vec++; if (active_out !== 3'b000) begin n_err++; $display("FAIL const_active t=%0d: got %b want 000", t, active_out); end
      end
    end
  endtask

  task automatic test_duty_pattern();
    do_reset();
    enable = 1'b1; duty_ready = 1'b1;
    for (int t = 1; t <= 64; t++) begin
      pwm_in = 3'b000;
      pwm_in[1] = ((t - 1) % 16) < 4;
      tick();
      if (t >= 32 && (t % 16) == 0) begin
        n_vec++; if (duty_valid !== 1'b1) begin n_err++; $display("FAIL pat_valid t=%0d: got %b want 1", t, duty_valid); end
        n_vec++; if (ch(duty_out, 1) != 4) begin n_err++; $display("FAIL pat_ch1 t=%0d: got %0d want 4", t, ch(duty_out, 1)); end
        n_vec++; if (ch(duty_out, 2) != 0 || ch(duty_out, 0) != 0) begin n_err++; $display("FAIL pat_ch02 t=%0d: got %h want ch0=ch2=0", t, duty_out); end
        n_vec++; if (active_out !== 3'b010) begin n_err++; $display("FAIL pat_active t=%0d: got %b want 010", t, active_out); end
      end
    end
  endtask

  task automatic test_overrun();
    do_reset();
    pwm_in = 3'b001; enable = 1'b1; duty_ready = 1'b0;
    for (int t = 1; t <= 48; t++) begin
      tick();
      if (t >= 16) begin
        n_vec++; if (duty_valid !== 1'b1) begin n_err++; $display("FAIL ovr_valid t=%0d: got %b want 1", t, duty_valid); end
        n_vec++; if (ch(duty_out, 0) != 14) begin n_err++; $display("FAIL ovr_hold t=%0d: got %0d want 14", t, ch(duty_out, 0)); end
      end
      if (t == 16 || t == 31) begin
        n_vec++; if (overrun !== 1'b0) begin n_err++; $display("FAIL ovr_early t=%0d: got %b want 0", t, overrun); end
      end
      if (t == 32 || t == 40 || t == 48) begin
        n_vec++; if (overrun !== 1'b1) begin n_err++; $display("FAIL ovr_set t=%0d: got %b want 1", t, overrun); end
      end
    end
    clr_overrun = 1'b1;
    tick();
    clr_overrun = 1'b0;
    n_vec++; if (overrun !== 1'b0) begin n_err++; $display("FAIL ovr_clear: got %b want 0", overrun); end
    duty_ready = 1'b1;
    tick();
    n_vec++; if (duty_valid !== 1'b0) begin n_err++; $display("FAIL ovr_accept_valid: got %b want 0", duty_valid); end
    n_vec++; if (ch(duty_out, 0) != 14) begin n_err++; $display("FAIL ovr_accept_hold: got %0d want 14", ch(duty_out, 0)); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    pwm_in = 3'b001; enable = 1'b1; duty_ready = 1'b0;
    for (int t = 1; t <= 31; t++) tick();
    n_vec++; if (duty_valid !== 1'b1 || ch(duty_out, 0) != 14) begin n_err++; $display("FAIL b2b_first: got valid=%b ch0=%0d want 1/14", duty_valid, ch(duty_out, 0)); end
    duty_ready = 1'b1;
    tick();
    n_vec++; if (duty_valid !== 1'b1) begin n_err++; $display("FAIL b2b_valid: got %b want 1", duty_valid); end
    n_vec++; if (ch(duty_out, 0) != 16) begin n_err++; $display("FAIL b2b_ch0: got %0d want 16", ch(duty_out, 0)); end
    n_vec++; if (overrun !== 1'b0) begin n_err++; $display("FAIL b2b_overrun: got %b want 0", overrun); end
    n_vec++; if (active_out !== 3'b000) begin n_err++; $display("FAIL b2b_active: got %b want 000", active_out); end
    tick();
    n_vec++; if (duty_valid !== 1'b0) begin n_err++; $display("FAIL b2b_drop: got %b want 0", duty_valid); end
  endtask

  task automatic test_enable_abort();
    logic exp_v;
    do_reset();
    pwm_in = 3'b001; enable = 1'b1; duty_ready = 1'b1;
    for (int t = 1; t <= 23; t++) tick();
    enable = 1'b0;
    for (int t = 0; t < 5; t++) begin
      tick();
      n_vec++; if (duty_valid !== 1'b0) begin n_err++; $display("FAIL abort_idle t=%0d: got %b want 0", t, duty_valid); end
    end
    enable = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      tick();
      exp_v = (k == 16);
      n_vec++; if (duty_valid !== exp_v) begin n_err++; $display("FAIL abort_valid k=%0d: got %b want %b", k, duty_valid, exp_v); end
    end
    n_vec++; if (ch(duty_out, 0) != 16) begin n_err++; $display("FAIL abort_ch0: got %0d want 16", ch(duty_out, 0)); end
    n_vec++; if (active_out !== 3'b000) begin n_err++; $display("FAIL abort_active: got %b want 000", active_out); end
  endtask

  task automatic test_async_reset();
    logic exp_v;
    do_reset();
    pwm_in = 3'b001; enable = 1'b1; duty_ready = 1'b0;
    for (int t = 1; t <= 36; t++) tick();
    n_vec++; if (duty_valid !== 1'b1 || overrun !== 1'b1) begin n_err++; $display("FAIL arst_pre: got valid=%b ovr=%b want 1/1", duty_valid, overrun); end
    #2 rst_n = 1'b0;
    #1;
    n_vec++; if (duty_out !== '0 || active_out !== '0) begin n_err++; $display("FAIL arst_data: got %h/%b want 0/0", duty_out, active_out); end
    n_vec++; if (duty_valid !== 1'b0 || overrun !== 1'b0) begin n_err++; $display("FAIL arst_flags: got valid=%b ovr=%b want 0/0", duty_valid, overrun); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      tick();
      exp_v = (k == 16);
      n_vec++; if (duty_valid !== exp_v) begin n_err++; $display("FAIL arst_valid k=%0d: got %b want %b", k, duty_valid, exp_v); end
    end
    n_vec++; if (ch(duty_out, 0) != 14) begin n_err++; $display("FAIL arst_ch0: got %0d want 14", ch(duty_out, 0)); end
  endtask

  task automatic test_random();
    int rdy_pct;
    do_reset();
    for (int t = 0; t < 1600; t++) begin
      case (t / 400)
        0: rdy_pct = 80;
        1: rdy_pct = 15;
        2: rdy_pct = 50;
        default: rdy_pct = 100;
      endcase
      pwm_in      = pwm_in ^ (C'($urandom) & C'($urandom));
      enable      = ($urandom_range(0, 39) != 0);
      duty_ready  = ($urandom_range(0, 99) < rdy_pct);
      clr_overrun = ($urandom_range(0, 24) == 0);
      tick();
      n_vec++;
      if (duty_out !== m_duty || active_out !== m_act || duty_valid !== m_valid || overrun !== m_ovr) begin
        n_err++;
        $display("FAIL rand t=%0d: got duty=%h act=%b v=%b ovr=%b want duty=%h act=%b v=%b ovr=%b",
                 t, duty_out, active_out, duty_valid, overrun, m_duty, m_act, m_valid, m_ovr);
      end
    end
  endtask

  initial begin
    test_reset();
    test_constant();
    test_duty_pattern();
    test_overrun();
    test_back_to_back();
    test_enable_abort();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
